// File: rtl/picosoc_arb_pkg.sv
// Shared types and constants for the two-master PicoSoC SRAM arbiter.
package picosoc_arb_pkg;

  localparam int unsigned ARB_NUM_M   = 2;
  localparam int unsigned ARB_GRANT_W = ARB_NUM_M;
  localparam int unsigned ARB_M0      = 0;
  localparam int unsigned ARB_M1      = 1;
  localparam int unsigned ARB_RAM_AW  = 22;
  localparam int unsigned ARB_DW      = 32;
  localparam int unsigned ARB_SW      = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  typedef logic [ARB_GRANT_W-1:0] arb_grant_t;

endpackage

// File: rtl/picosoc_arb_pick.sv
// Winner selection for the SRAM arbiter; PICOSOC_MEM_ARB_RR_EN selects
// round-robin (with its preference pointer) instead of fixed m0 priority.
module picosoc_arb_pick
  import picosoc_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  arb_grant_t req,
  input  logic       advance,
  output arb_grant_t win_c
);

`ifdef PICOSOC_MEM_ARB_RR_EN
  logic ptr_q;
  logic ptr_d;

  // Pointer names the preferred master; after a grant it moves to the non-owner.
  always_comb begin
    win_c = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      win_c = ptr_q ? 2'b10 : 2'b01;
    end
    if (advance) begin
      ptr_d = win_c[ARB_M0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_pick;

  always_comb begin
    win_c = req;
    if (req[ARB_M0]) begin
      win_c = 2'b01;
    end
  end

  assign unused_pick = ^{clk, reset, advance};
`endif

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Serializes PicoRV32 and a second bus master onto the single-port SRAM:
// issue in IDLE, respond in RESP. PICOSOC_MEM_ARB_RR_EN enables round-robin.
module picosoc_mem_arbiter
  import picosoc_arb_pkg::*;
#(
  parameter int unsigned WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic [3:0]  ram_wen,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned UNUSED_WORDS = WORDS;

  arb_state_e state_q;
  arb_state_e state_d;
  arb_grant_t grant_q;
  arb_grant_t grant_d;
  arb_grant_t win_c;
  logic       issue_c;
  logic       unused_addr;

  picosoc_arb_pick u_pick (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_valid, m0_valid}),
    .advance (issue_c),
    .win_c   (win_c)
  );

  // Issue is combinational in IDLE; RESP holds the address and returns data.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    issue_c   = 1'b0;
    ram_wen   = '0;
    ram_addr  = m0_addr[23:2];
    ram_wdata = m0_wdata;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (win_c[ARB_M1]) begin
          ram_addr  = m1_addr[23:2];
          ram_wdata = m1_wdata;
        end
        if ((|win_c) && !reset) begin
          issue_c = 1'b1;
          state_d = ARB_RESP;
          grant_d = win_c;
          ram_wen = win_c[ARB_M1] ? m1_wstrb : m0_wstrb;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        // ready is withheld if the owner dropped valid or reset cuts the cycle
        if (grant_q[ARB_M1]) begin
          ram_addr  = m1_addr[23:2];
          ram_wdata = m1_wdata;
          m1_ready  = m1_valid && !reset;
          m1_rdata  = ram_rdata;
        end else begin
          m0_ready  = m0_valid && !reset;
          m0_rdata  = ram_rdata;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ARB_RESP);

  assign unused_addr = ^{m0_addr[31:24], m0_addr[1:0], m1_addr[31:24], m1_addr[1:0]};

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Directed bench for picosoc_mem_arbiter with an SRAM model and a response
// scoreboard; expectations follow PICOSOC_MEM_ARB_RR_EN when it is defined.
module tb_picosoc_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [1:0]  grant;
  logic        busy;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          order_q[$];
  int          tests = 0;
  int          failed = 0;
  logic        seen0, seen1;
  logic        prev_wen_nz = 1'b0;
  int          wen_cycles = 0;
  logic [3:0]  last_wen = '0;
  int          wr_count = 0;
  logic [31:0] mem [256];

  picosoc_mem_arbiter #(.WORDS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_valid  (m0_valid),
    .m0_ready  (m0_ready),
    .m0_wstrb  (m0_wstrb),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_ready  (m1_ready),
    .m1_wstrb  (m1_wstrb),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM with byte enables; counts cycles that write.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wen[b]) mem[8'(ram_addr)][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    if (|ram_wen) wr_count <= wr_count + 1;
    ram_rdata <= mem[8'(ram_addr)];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs at every sampling point: response scoreboard and bus invariants.
  task automatic mon();
    exp_t e;
    int   o;
    check("wen_consecutive", 32'(prev_wen_nz && (|ram_wen)), 32'd0);
    if (|ram_wen) begin
      wen_cycles++;
      last_wen = ram_wen;
    end
    prev_wen_nz = |ram_wen;
    check("both_ready", 32'(m0_ready && m1_ready), 32'd0);
    if (!busy) begin
      check("idle_ready", 32'({m1_ready, m0_ready}), 32'd0);
      check("idle_m0_rdata", m0_rdata, 32'd0);
      check("idle_m1_rdata", m1_rdata, 32'd0);
    end
    if (m0_ready) begin
      seen0 = 1'b1;
      check("m0_grant", 32'(grant), 32'd1);
      if (order_q.size() == 0 || q0.size() == 0) begin
        check("m0_unexpected_ready", 32'(m0_ready), 32'd0);
      end else begin
        o = order_q.pop_front();
        check("grant_order", 32'd0, 32'(o));
        e = q0.pop_front();
        if (e.chk) check("m0_rdata", m0_rdata, e.data);
      end
    end
    if (m1_ready) begin
      seen1 = 1'b1;
      check("m1_grant", 32'(grant), 32'd2);
      if (order_q.size() == 0 || q1.size() == 0) begin
        check("m1_unexpected_ready", 32'(m1_ready), 32'd0);
      end else begin
        o = order_q.pop_front();
        check("grant_order", 32'd1, 32'(o));
        e = q1.pop_front();
        if (e.chk) check("m1_rdata", m1_rdata, e.data);
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    mon();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    neg();
    pos();
  endtask

  task automatic push(input int m, input logic chk, input logic [31:0] data);
    exp_t e;
    e.chk  = chk;
    e.data = data;
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
    order_q.push_back(m);
  endtask

  // One complete access from master m; lat is cycles from request to ready.
  task automatic xfer(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp, output int lat);
    push(m, strb == 4'b0000, exp);
    if (m == 0) begin
      m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb; m0_valid = 1'b1;
    end else begin
      m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb; m1_valid = 1'b1;
    end
    seen0 = 1'b0;
    seen1 = 1'b0;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if ((m == 0) ? seen0 : seen1) begin
        lat = k;
        break;
      end
    end
    check("xfer_completed", 32'(lat >= 0), 32'd1);
    if (m == 0) m0_valid = 1'b0;
    else m1_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int w0;
    int wc0;
    reset = 1'b1;
    m0_valid = 1'b1; m0_wstrb = 4'hF; m0_addr = 32'h40; m0_wdata = 32'hDEAD_BEEF;
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0;  m1_wdata = 32'h0;
    seen0 = 1'b0; seen1 = 1'b0;

    // Reset: nothing issued even with a pending write
    pos();
    neg();
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    pos();
    m0_valid = 1'b0;
    m0_wstrb = 4'h0;
    step();
    reset = 1'b0;
    step();
    check("rst_no_write", 32'(wr_count), 32'd0);

    // Preload and single read
    xfer(0, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, lat);
    xfer(0, 32'h40, 32'h0, 4'h0, 32'hCAFE_F00D, lat);
    check("m0_read_latency", 32'(lat), 32'd1);

    // Byte write from m1 and readback
    w0 = wr_count;
    wc0 = wen_cycles;
    xfer(1, 32'h40, 32'h1122_3344, 4'b0010, 32'h0, lat);
    check("byte_wr_wen_cycles", 32'(wen_cycles - wc0), 32'd1);
    check("byte_wr_wen_value", 32'(last_wen), 32'b0010);
    check("byte_wr_count", 32'(wr_count - w0), 32'd1);
    xfer(1, 32'h40, 32'h0, 4'h0, 32'hCAFE_330D, lat);
    check("m1_read_latency", 32'(lat), 32'd1);
    xfer(1, 32'h80, 32'hB0B0_0001, 4'hF, 32'h0, lat);

    // Contention: both masters request for 8 cycles
`ifdef PICOSOC_MEM_ARB_RR_EN
    push(0, 1'b1, 32'hCAFE_330D);
    push(1, 1'b1, 32'hB0B0_0001);
    push(0, 1'b1, 32'hCAFE_330D);
    push(1, 1'b1, 32'hB0B0_0001);
`else
    for (int i = 0; i < 4; i++) push(0, 1'b1, 32'hCAFE_330D);
    push(1, 1'b1, 32'hB0B0_0001);
`endif
    m0_addr = 32'h40; m0_wstrb = 4'h0; m0_valid = 1'b1;
    m1_addr = 32'h80; m1_wstrb = 4'h0; m1_valid = 1'b1;
    repeat (8) step();
    m0_valid = 1'b0;
    for (int k = 0; k < 6 && q1.size() != 0; k++) step();
    m1_valid = 1'b0;
    check("cont_order_left", 32'(order_q.size()), 32'd0);
    check("cont_q0_left", 32'(q0.size()), 32'd0);
    check("cont_q1_left", 32'(q1.size()), 32'd0);
    step();

    // Reset asserted in RESP after a write was issued
    w0 = wr_count;
    m0_addr = 32'h44; m0_wdata = 32'hA5A5_0001; m0_wstrb = 4'hF; m0_valid = 1'b1;
    neg();
    check("rresp_issue_wen", 32'(ram_wen), 32'hF);
    pos();
    reset = 1'b1;
    neg();
    check("rresp_no_ready", 32'(m0_ready), 32'd0);
    pos();
    reset = 1'b0;
    m0_valid = 1'b0;
    m0_wstrb = 4'h0;
    neg();
    check("rresp_grant", 32'(grant), 32'd0);
    check("rresp_busy", 32'(busy), 32'd0);
    check("rresp_write_once", 32'(wr_count - w0), 32'd1);
    pos();
    xfer(0, 32'h44, 32'h0, 4'h0, 32'hA5A5_0001, lat);
    check("rresp_next_latency", 32'(lat), 32'd1);
    check("rresp_still_once", 32'(wr_count - w0), 32'd1);

    // Owner drops valid during RESP
    m1_addr = 32'h40; m1_wstrb = 4'h0; m1_valid = 1'b1;
    neg();
    pos();
    m1_valid = 1'b0;
    neg();
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_grant", 32'(grant), 32'd2);
    check("drop_no_ready", 32'(m1_ready), 32'd0);
    pos();
    neg();
    check("drop_idle_busy", 32'(busy), 32'd0);
    check("drop_idle_grant", 32'(grant), 32'd0);
    pos();
    xfer(0, 32'h40, 32'h0, 4'h0, 32'hCAFE_330D, lat);
    check("drop_next_latency", 32'(lat), 32'd1);

    repeat (3) step();
    check("final_order_left", 32'(order_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
